dmem_port_arbiter: RTL
======================

Name: dmem_port_arbiter

Overview:
- Shares one synchronous data-memory port between two requesters: port 0 (CPU-side data path) and port 1 (debug loader / DMA-style master).
- Uses a req/ack handshake per port and round-robin arbitration.
- Sits between the requesters and the data memory; it is the only block that drives the memory address, write data and write enable.

Parameters:
- ADDR_W, 32, address width of every port.
- DATA_W, 32, data width of every port.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 request; held high until m0_ack.
- m0_we  in  1  port 0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rdata  out  DATA_W  port 0 read data, valid with m0_ack and held until the next port-0 read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as port 0, for port 1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data; valid one cycle after the address is sampled.
- busy  out  1  high in any state except IDLE.
- owner  out  1  current or last granted port.

Behaviour:
- Reset is asynchronous, entered immediately and regardless of state.
  - Outputs: all acks 0, all rdata 0, mem_addr 0, mem_wdata 0, mem_we 0, busy 0, owner 0.
  - State goes to IDLE; last_owner is set to 1, so port 0 wins the first tie.
- States: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. All outputs are registered.
- IDLE: arbitration happens here only.
  - No req: stay in IDLE.
  - One req: grant that port.
  - Both reqs: grant the port that is not last_owner.
  - On grant: capture the winner's we/addr/wdata into mem_addr/mem_wdata/mem_we, set owner and last_owner, go to ACCESS.
- ACCESS: mem_* signals are driven for exactly one cycle; mem_we is high only in this state, and only for a write. Next state is WAIT.
- WAIT: mem_we is 0. For a read, capture mem_rdata into the owner's rdata register at the end of the cycle. Next state is RESP.
- RESP: the owner's ack is 1 for exactly this cycle; the other ack stays 0. Next state is IDLE.
- Latency: req first sampled high in IDLE at cycle N gives ack in cycle N+3. This is the same for reads and writes.
- Throughput: at most one transaction per 4 cycles.
- Handshake rules:
  - The requester holds req/we/addr/wdata stable until ack.
  - After ack it either drops req or presents a new transaction from the cycle following ack.
  - A req seen in IDLE is always treated as a new transaction.
- Early req deassert (illegal): the captured transaction still completes and ack is still pulsed.
- Writes: the port's rdata is unchanged; ack still pulses.
- Between transactions, mem_addr/mem_wdata hold their last values and mem_we is 0.
- Fairness: with both ports requesting continuously, grants strictly alternate, so a waiting port waits at most 4 cycles (one competing transaction).
- Reset asserted in ACCESS drops the write immediately (mem_we falls asynchronously). The in-flight transaction gets no ack.

Decomposition:
- Shared package: state encodings (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3) and port ids (PORT0=1'b0, PORT1=1'b1).
- One sub-module, arb_rr2: a combinational 2-way round-robin picker.
  - Inputs: req0, req1, last.
  - Outputs: gnt_valid, gnt_id.
- The FSM, datapath capture and rdata registers stay in dmem_port_arbiter.

Test Plan:
- Reset:
  - Stimulus: hold resetn low, then release; no requests.
  - Required: every output is 0, busy=0, and mem_we never rises.
- Port 0 single write, then read:
  - Stimulus: m0 write, addr 0x10, data 0xDEADBEEF; then a read of 0x10 using a memory model.
  - Required: mem_we high only in cycle N+1; m0_ack in N+3; the read returns m0_rdata=0xDEADBEEF with its ack; m1_ack stays 0 throughout.
- Simultaneous requests from reset:
  - Stimulus: both ports read (m0 addr 0x4, m1 addr 0x8).
  - Required: port 0 is served first (owner=0, ack at N+3), then port 1 (mem_addr=0x8, m1_ack at N+7).
- Continuous contention:
  - Stimulus: both reqs held high for 8 transactions.
  - Required: owner sequence is 0,1,0,1,...; each port gets 4 acks; no port waits more than one competing transaction.
- Port 1 write sharing memory with port 0:
  - Stimulus: m1 writes 0x1234 to 0x20, then m0 reads 0x20.
  - Required: m0_rdata=0x00001234; m1_rdata is unchanged from its prior value.
- Mid-transaction reset:
  - Stimulus: assert resetn low during ACCESS of an m0 write.
  - Required: mem_we drops immediately; the memory word is not written; no ack pulse; after release, state is IDLE.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Purpose: shared encodings for the two-port data-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_port_arbiter_pkg;

    // Transaction phases: arbitrate, drive memory, await read data, acknowledge.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Purpose: bundles both requester handshakes and the memory-side port.
// Latency: n/a (wiring only).
// Backpressure: req is held by the requester until its one-cycle ack.
// Ports: m0_*/m1_* requester req/we/addr/wdata in, ack/rdata out;
//        mem_* towards the synchronous RAM; busy/owner status.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    // Arbiter side.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output mem_addr, mem_wdata, mem_we,
        output busy, owner
    );

    // Requester / memory-model side.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  mem_addr, mem_wdata, mem_we,
        input  busy, owner
    );
endinterface

// File: rtl/arb_rr2.sv
// Purpose: combinational two-way round-robin picker.
// Latency: zero (pure combinational).
// Backpressure: none; caller decides when a pick is consumed.
// Ports: req0/req1 requests, last = previously granted id; gnt_valid/gnt_id.
module arb_rr2
    import dmem_port_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;
    // On a tie the port that did not win last time goes next.
    assign gnt_id    = (req0 && req1) ? ~last : (req1 ? PORT1 : PORT0);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Purpose: shares one synchronous data-memory port between two req/ack masters.
// Latency: req sampled in IDLE at cycle N -> ack at N+3; one transaction per 4 cycles.
// Backpressure: a losing requester simply keeps req high until it is granted.
// Ports: clk, resetn (async active-low), bus (slave modport of dmem_port_arbiter_if).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    dmem_port_arbiter_if.slave   bus
);

    state_e              state_q, state_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q, owner_d;
    logic                txn_we_q, txn_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q, busy_d;

    logic                gnt_valid;
    logic                gnt_id;

    arb_rr2 u_arb (
        .req0      (bus.m0_req),
        .req1      (bus.m1_req),
        .last      (last_owner_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        txn_we_d     = txn_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    state_d      = ST_ACCESS;
                    owner_d      = gnt_id;
                    last_owner_d = gnt_id;
                    if (gnt_id == PORT1) begin
                        mem_addr_d  = bus.m1_addr;
                        mem_wdata_d = bus.m1_wdata;
                        mem_we_d    = bus.m1_we;
                        txn_we_d    = bus.m1_we;
                    end else begin
                        mem_addr_d  = bus.m0_addr;
                        mem_wdata_d = bus.m0_wdata;
                        mem_we_d    = bus.m0_we;
                        txn_we_d    = bus.m0_we;
                    end
                end
            end
            ST_ACCESS: begin
                // The RAM samples the address at the end of this cycle.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Read data is on mem_rdata now; ack is registered so it lands in RESP.
                state_d = ST_RESP;
                if (owner_q == PORT0) begin
                    ack0_d = 1'b1;
                    if (!txn_we_q) rdata0_d = bus.mem_rdata;
                end else begin
                    ack1_d = 1'b1;
                    if (!txn_we_q) rdata1_d = bus.mem_rdata;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            last_owner_q <= PORT1;
            owner_q      <= PORT0;
            txn_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            txn_we_q     <= txn_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.m0_ack    = ack0_q;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_ack    = ack1_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;

endmodule
